// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_pkg
// Description : Shared types and constants for the PSRAM request sequencer:
//               read_write codes, QPI command bytes, FSM state encoding and
//               the request record held in the request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package psram_pkg;

   // read_write codes understood by the PSRAM top
   localparam logic [1:0] RW_IDLE  = 2'd0;
   localparam logic [1:0] RW_WRITE = 2'd1;
   localparam logic [1:0] RW_READ  = 2'd2;

   // QPI command bytes issued by the PSRAM top for each transfer type
   localparam logic [7:0] CMD_READ  = 8'hEB;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_WAIT_INIT = 3'd0,
      ST_IDLE      = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_END  = 3'd3,
      ST_DONE      = 3'd4,
      ST_GAP       = 3'd5
   } seq_state_e;

   // One buffered request: {we, addr, wdata} = 40 bits
   typedef struct packed {
      logic        we;
      logic [22:0] addr;
      logic [15:0] wdata;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   // Map a write-enable onto the PSRAM top read_write code
   function automatic logic [1:0] rw_code(input logic we);
      return we ? RW_WRITE : RW_READ;
   endfunction

endpackage
`default_nettype wire

// File: rtl/psram_req_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : psram_req_sequencer_if
// Description : Bundle of the client request/response port and the PSRAM top
//               command port. 'master' is the sequencer view, 'slave' the
//               view of the client plus PSRAM top around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface psram_req_sequencer_if;

   // client request / response side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [22:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        err_timeout;
   logic        busy;

   // PSRAM top side
   logic        qpi_on;
   logic        endcommand;
   logic [15:0] data_out;
   logic [23:0] address;
   logic [1:0]  read_write;
   logic        quad_start;
   logic [15:0] data_in;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      input  qpi_on, endcommand, data_out,
      output req_ready, rsp_valid, rsp_rdata, err_timeout, busy,
      output address, read_write, quad_start, data_in
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      output qpi_on, endcommand, data_out,
      input  req_ready, rsp_valid, rsp_rdata, err_timeout, busy,
      input  address, read_write, quad_start, data_in
   );

endinterface
`default_nettype wire

// File: rtl/psram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : psram_req_fifo
// Description : Synchronous request FIFO. First-word-fall-through read port
//               (dout shows the head entry). Simultaneous push and pop is
//               accepted when full; a push into a full FIFO without a pop is
//               dropped. DEPTH must be a power of two so pointers wrap free.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] din,
   output logic                  full,
   output logic                  empty,
   output logic [WIDTH-1:0]      dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // Pointer/count update; a pop frees the slot a same-cycle push may use
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state: reset empties the FIFO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array: contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/psram_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : psram_req_sequencer
// Description : Client-side sequencer for the PSRAM top. Buffers word
//               requests, issues each as a one-cycle quad_start with stable
//               address/read_write/data_in, waits for endcommand (or times
//               out), returns read data and enforces a CE-high gap.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_req_sequencer
   import psram_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GAP_CYCLES     = 2
) (
   input  wire logic              mem_clk,
   input  wire logic              rst_n,
   psram_req_sequencer_if.master  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

   seq_state_e        state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [GW-1:0]     gap_q,   gap_d;
   logic [23:0]       addr_q,  addr_d;
   logic [1:0]        rw_q,    rw_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rsp_rdata_q, rsp_rdata_d;
   logic              err_q,   err_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [REQ_W-1:0]  fifo_dout;
   req_t              new_req;
   req_t              head;

   assign new_req   = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
   assign head      = fifo_dout;
   assign fifo_push = bus.req_valid && bus.req_ready;

   psram_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk   (mem_clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (new_req),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   // Client and PSRAM-facing outputs
   assign bus.req_ready   = (state_q != ST_WAIT_INIT) && !fifo_full;
   assign bus.quad_start  = (state_q == ST_ISSUE);
   assign bus.address     = addr_q;
   assign bus.read_write  = rw_q;
   assign bus.data_in     = wdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.err_timeout = err_q;
   assign bus.busy        = ((state_q != ST_IDLE) && (state_q != ST_WAIT_INIT)) || !fifo_empty;

   // Next-state and datapath: one transaction at a time, endcommand only
   // honoured while waiting for it
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      gap_d       = gap_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      err_d       = err_q;
      fifo_pop    = 1'b0;

      case (state_q)
         ST_WAIT_INIT: begin
            if (bus.qpi_on) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!bus.qpi_on) begin
               // queued requests stay buffered until the PSRAM is back
               state_d = ST_WAIT_INIT;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               addr_d   = {1'b0, head.addr};
               rw_d     = rw_code(head.we);
               wdata_d  = head.wdata;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            if (bus.endcommand) begin
               // read data is captured with endcommand so it lines up with rsp_valid
               if (rw_q == RW_READ) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = bus.data_out;
               end
               state_d = ST_DONE;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = 1'b1;
               rw_d    = RW_IDLE;
               gap_d   = '0;
               state_d = ST_GAP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_DONE: begin
            rw_d    = RW_IDLE;
            gap_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_WAIT_INIT;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge mem_clk) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT_INIT;
         timer_q     <= '0;
         gap_q       <= '0;
         addr_q      <= '0;
         rw_q        <= RW_IDLE;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         gap_q       <= gap_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         err_q       <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psram_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psram_req_sequencer
// Description : Self-checking bench. A behavioural PSRAM device answers each
//               quad_start after a chosen latency; a transaction-level
//               reference (request order, memory contents, timeout window,
//               response timing) predicts what the sequencer must do.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_req_sequencer;
   import psram_pkg::*;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int GAP_CYCLES     = 2;

   logic mem_clk = 1'b0;
   logic rst_n   = 1'b0;

   psram_req_sequencer_if bus ();

   psram_req_sequencer #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES)
   ) dut (
      .mem_clk (mem_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 mem_clk = ~mem_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge mem_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Power-on contents of the device memory
   function automatic logic [15:0] mem_init(input logic [22:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic        we;
      logic [22:0] addr;
      logic [15:0] wdata;
   } req_s;

   typedef struct {
      int          due;
      logic [15:0] data;
   } rsp_s;

   req_s        exp_q[$];
   rsp_s        rsp_q[$];
   logic [15:0] ref_mem [logic [22:0]];
   req_s        cur;
   logic [15:0] cur_rdata;
   bit          inflight      = 0;
   bit          exp_err       = 0;
   int          q_cyc         = 0;
   int          last_end_cyc  = -1000;
   int          n_qs          = 0;
   int          last_push_cyc = 0;
   int          last_qs_cyc   = 0;
   logic [15:0] last_rsp_data = '0;

   function automatic logic [15:0] ref_read(input logic [22:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
   endfunction

   // Observes the DUT mid-cycle and compares against the reference
   always @(negedge mem_clk) begin : mon
      if (!rst_n) begin
         exp_q.delete();
         rsp_q.delete();
         inflight     = 0;
         exp_err      = 0;
         last_end_cyc = -1000;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            exp_q.push_back('{bus.req_we, bus.req_addr, bus.req_wdata});
            last_push_cyc = cyc;
         end

         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            check("rsp_valid", bus.rsp_valid, 1);
            check("rsp_rdata", bus.rsp_rdata, rsp_q[0].data);
            last_rsp_data = bus.rsp_rdata;
            void'(rsp_q.pop_front());
         end else if (bus.rsp_valid) begin
            check("rsp_unexpected", bus.rsp_valid, 0);
         end

         // endcommand is accepted from 1 to TIMEOUT_CYCLES cycles after
         // quad_start; the sticky error is visible the cycle after that window
         if (inflight) begin
            if (cyc - q_cyc == TIMEOUT_CYCLES + 1) begin
               exp_err = 1;
               check("err_timeout_set", bus.err_timeout, 1);
               check("timeout_rw_idle", bus.read_write, RW_IDLE);
               inflight     = 0;
               last_end_cyc = q_cyc + TIMEOUT_CYCLES;
            end else if (cyc > q_cyc && bus.endcommand) begin
               check("hold_address", bus.address, {1'b0, cur.addr});
               check("hold_rw", bus.read_write, cur.we ? RW_WRITE : RW_READ);
               check("hold_data_in", bus.data_in, cur.wdata);
               check("err_at_end", bus.err_timeout, exp_err);
               if (!cur.we) rsp_q.push_back('{cyc + 1, cur_rdata});
               inflight     = 0;
               last_end_cyc = cyc;
            end else if (cyc - q_cyc == TIMEOUT_CYCLES) begin
               check("err_before_timeout", bus.err_timeout, exp_err);
            end
         end

         if (bus.quad_start) begin
            n_qs++;
            last_qs_cyc = cyc;
            check("qs_overlap", inflight, 0);
            if (exp_q.size() == 0) begin
               check("qs_unexpected", bus.quad_start, 0);
            end else begin
               cur = exp_q.pop_front();
               check("issue_address", bus.address, {1'b0, cur.addr});
               check("issue_rw", bus.read_write, cur.we ? RW_WRITE : RW_READ);
               if (cur.we) begin
                  check("issue_data_in", bus.data_in, cur.wdata);
                  ref_mem[cur.addr] = cur.wdata;
               end else begin
                  cur_rdata = ref_read(cur.addr);
               end
               check("gap_min", (cyc - last_end_cyc - 1) >= GAP_CYCLES, 1);
               inflight = 1;
               q_cyc    = cyc;
            end
         end
      end
   end

   // ---------------- behavioural PSRAM device ----------------
   // fixed_lat: 0 = random 1..30, -1 = never answer, else exact latency
   int fixed_lat = 0;

   initial begin : psram_dev
      int          cnt = 0;
      int          lat = 0;
      bit          active = 0;
      bit          hold = 0;
      logic [23:0] m_addr = '0;
      logic [1:0]  m_rw = '0;
      logic [15:0] m_din = '0;
      logic [15:0] dev_mem [logic [22:0]];
      bus.endcommand = 1'b0;
      bus.data_out   = '0;
      forever begin
         @(posedge mem_clk);
         #1;
         if (active) begin
            cnt++;
            if (cnt == 1 && hold) bus.endcommand = 1'b0;
            if (cnt == lat) begin
               bus.endcommand = 1'b1;
               if (m_rw == RW_WRITE) dev_mem[m_addr[22:0]] = m_din;
               else bus.data_out = dev_mem.exists(m_addr[22:0]) ? dev_mem[m_addr[22:0]]
                                                                 : mem_init(m_addr[22:0]);
            end
            if (cnt == lat + 1) begin
               if (!hold) bus.endcommand = 1'b0;
               active = 0;
            end
         end
         if (bus.quad_start) begin
            active = 1;
            cnt    = 0;
            m_addr = bus.address;
            m_rw   = bus.read_write;
            m_din  = bus.data_in;
            // hold=1 leaves endcommand high until after the next start
            hold   = 1'($urandom_range(0, 1));
            lat    = (fixed_lat == 0) ? int'($urandom_range(1, 30)) : fixed_lat;
            if (!hold) bus.endcommand = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_req(input logic we, input logic [22:0] a, input logic [15:0] d);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge mem_clk);
      while (!bus.req_ready && n < 500) begin
         @(negedge mem_clk);
         n++;
      end
      if (!bus.req_ready) check("push_accept_timeout", bus.req_ready, 1);
      @(posedge mem_clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      @(negedge mem_clk);
      while ((bus.busy || inflight || exp_q.size() > 0 || rsp_q.size() > 0) && n < max_cyc) begin
         @(negedge mem_clk);
         n++;
      end
      if (n >= max_cyc) check("idle_wait_timeout", bus.busy, 0);
      @(posedge mem_clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"},   bus.req_ready,   0);
      check({pfx, "_rsp_valid"},   bus.rsp_valid,   0);
      check({pfx, "_rsp_rdata"},   bus.rsp_rdata,   0);
      check({pfx, "_err_timeout"}, bus.err_timeout, 0);
      check({pfx, "_busy"},        bus.busy,        0);
      check({pfx, "_address"},     bus.address,     0);
      check({pfx, "_read_write"},  bus.read_write,  0);
      check({pfx, "_quad_start"},  bus.quad_start,  0);
      check({pfx, "_data_in"},     bus.data_in,     0);
   endtask

   // ---------------- test sequence ----------------
   initial begin : stim
      bit seen_ready;
      int acc;
      int qs_before;
      int n;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.qpi_on    = 1'b0;
      rst_n         = 1'b0;

      @(posedge mem_clk);
      @(negedge mem_clk);
      check_reset_outputs("por");
      @(posedge mem_clk);
      #1;
      rst_n = 1'b1;

      // 1: requests refused until the PSRAM top reports QPI mode
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 23'h55;
      bus.req_wdata = 16'hBEEF;
      seen_ready    = 0;
      repeat (6) begin
         @(negedge mem_clk);
         seen_ready |= bus.req_ready;
      end
      check("t1_ready_before_qpi", seen_ready, 0);
      check("t1_no_qs_before_qpi", n_qs, 0);
      @(posedge mem_clk);
      #1;
      bus.qpi_on = 1'b1;
      fixed_lat  = 5;
      push_req(1'b1, 23'h55, 16'hBEEF);
      wait_idle(300);
      check("t1_push_to_qs", last_qs_cyc - last_push_cyc, 2);

      // 2/3: write then read back the same word
      fixed_lat = 9;
      push_req(1'b1, 23'h10, 16'h1234);
      wait_idle(300);
      fixed_lat = 22;
      push_req(1'b0, 23'h10, 16'h0000);
      wait_idle(300);
      check("t3_rdata", last_rsp_data, 16'h1234);

      // shortest and longest accepted endcommand latency
      fixed_lat = 1;
      push_req(1'b0, 23'h55, 16'h0000);
      wait_idle(300);
      check("lat1_rdata", last_rsp_data, 16'hBEEF);
      fixed_lat = TIMEOUT_CYCLES;
      push_req(1'b0, 23'h20, 16'h0000);
      wait_idle(300);
      check("lat_max_no_err", bus.err_timeout, 0);

      // 4: back-to-back requests fill the FIFO behind one in flight
      fixed_lat     = 30;
      acc           = 0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.req_we    = 1'($urandom_range(0, 1));
         bus.req_addr  = 23'($urandom_range(0, 7));
         bus.req_wdata = 16'($urandom);
         @(negedge mem_clk);
         if (bus.req_ready) acc++;
         @(posedge mem_clk);
         #1;
      end
      check("t4_accepted", acc, FIFO_DEPTH + 1);
      check("t4_ready_when_full", bus.req_ready, 0);
      bus.req_valid = 1'b0;
      wait_idle(2000);

      // qpi_on falling: finish the current transfer, hold the queue
      fixed_lat = 10;
      push_req(1'b1, 23'h3, 16'h0A0A);
      push_req(1'b0, 23'h3, 16'h0000);
      push_req(1'b1, 23'h4, 16'h0B0B);
      bus.qpi_on = 1'b0;
      qs_before  = n_qs;
      repeat (40) @(negedge mem_clk);
      check("qpi_off_no_qs", n_qs - qs_before, 0);
      check("qpi_off_busy", bus.busy, 1);
      check("qpi_off_ready", bus.req_ready, 0);
      @(posedge mem_clk);
      #1;
      bus.qpi_on = 1'b1;
      wait_idle(500);
      check("qpi_on_drained", n_qs - qs_before, 2);

      // 5: device never answers -> sticky timeout, traffic continues
      fixed_lat = -1;
      push_req(1'b0, 23'h33, 16'h0000);
      wait_idle(500);
      check("t5_err", bus.err_timeout, 1);
      fixed_lat = 0;
      push_req(1'b1, 23'h34, 16'hC0DE);
      push_req(1'b0, 23'h34, 16'h0000);
      wait_idle(500);
      check("t5_err_sticky", bus.err_timeout, 1);
      check("t5_rdata_after_err", last_rsp_data, 16'hC0DE);

      // randomized traffic over a small address window
      for (int i = 0; i < 40; i++) begin
         n = int'($urandom_range(0, 3));
         repeat (n) begin
            @(posedge mem_clk);
            #1;
         end
         push_req(1'($urandom_range(0, 1)), 23'($urandom_range(0, 7)), 16'($urandom));
      end
      wait_idle(5000);

      // 6: reset while waiting for endcommand
      fixed_lat = 40;
      push_req(1'b0, 23'h5, 16'h0000);
      n = 0;
      while (!inflight && n < 50) begin
         @(negedge mem_clk);
         n++;
      end
      check("t6_started", inflight, 1);
      repeat (3) @(posedge mem_clk);
      #1;
      rst_n = 1'b0;
      @(posedge mem_clk);
      @(negedge mem_clk);
      check_reset_outputs("t6");
      @(posedge mem_clk);
      #1;
      rst_n     = 1'b1;
      qs_before = n_qs;
      repeat (60) @(negedge mem_clk);
      check("t6_no_qs_after_reset", n_qs - qs_before, 0);
      check("t6_busy_after_reset", bus.busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
